// File: rtl/caja_pkg.sv
// Shared types and constants for the gearbox shift sequencer.
//   shift_state_t : sequencer FSM states
//   M_*           : shift command encodings (2'b11 is reserved and treated as hold)
//   GEAR_NEUTRAL  : gear register value when the car is off
//   max_u         : constant helper for sizing the shared timer
package caja_pkg;

  typedef enum logic [2:0] {
    StOff,
    StIdle,
    StDisengage,
    StSelect,
    StEngage,
    StSettle
  } shift_state_t;

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;

  localparam logic [2:0] GEAR_NEUTRAL = 3'd0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_timer.sv
// Loadable down-counter shared by the DISENGAGE and SETTLE phases.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  synchronous active-low reset
//   load     in  load load_val this cycle (wins over en)
//   load_val in  value to load
//   en       in  decrement while non-zero
//   zero     out count is zero
module shift_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Automatic gearbox shift sequencer. Runs each accepted shift command through
// clutch-out (DISENGAGE), gear select, clutch-in (ENGAGE) and a settle hold-off.
// The only block that writes the gear register.
// Optional feature: define SHIFT_QUEUE_EN to keep a one-deep pending request
// captured while busy and replayed on return to IDLE.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  synchronous active-low reset
//   AC         in  car on; low forces OFF on the next edge
//   M[1:0]     in  shift command: 00 hold, 01 up, 10 down, 11 hold
//   gear[2:0]  out engaged gear, 0 = neutral
//   clutch     out 1 = clutch open
//   busy       out shift or settle in progress
//   shift_done out one-cycle pulse on clutch re-engage
//   reject     out one-cycle pulse on a refused request
module shift_sequencer
  import caja_pkg::*;
#(
  parameter int unsigned NUM_GEARS  = 5,
  parameter int unsigned CLUTCH_CYC = 4,
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       AC,
  input  logic [1:0] M,
  output logic [2:0] gear,
  output logic       clutch,
  output logic       busy,
  output logic       shift_done,
  output logic       reject
);

  localparam int unsigned CNT_W = $clog2(max_u(CLUTCH_CYC, SETTLE_CYC) + 1);
  // Timer is loaded with N-1 so that a phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] CLUTCH_LOAD = CNT_W'(CLUTCH_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [2:0]       GEAR_TOP    = 3'(NUM_GEARS);
  localparam logic [2:0]       GEAR_FIRST  = 3'd1;

  shift_state_t     state;
  logic             dir_up;
  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             eval_up;
  logic             eval_down;

  // Reload while waiting in OFF/IDLE so DISENGAGE starts with a fresh count,
  // and in ENGAGE so SETTLE does.
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = CLUTCH_LOAD;
    unique case (state)
      StOff, StIdle: tmr_load = 1'b1;
      StEngage: begin
        tmr_load = 1'b1;
        tmr_val  = SETTLE_LOAD;
      end
      StDisengage, StSettle: tmr_en = 1'b1;
      default: ;
    endcase
  end

  shift_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

`ifdef SHIFT_QUEUE_EN
  logic pend_valid;
  logic pend_up;

  // Pending can only be set while busy, so in IDLE a valid entry is always
  // the one captured during the shift just finished; it is consumed on the
  // first IDLE cycle.
  always_ff @(posedge clk) begin
    if (!reset || !AC) begin
      pend_valid <= 1'b0;
      pend_up    <= 1'b0;
    end else if ((state == StIdle) && pend_valid) begin
      pend_valid <= 1'b0;
    end else if (busy && ((M == M_UP) || (M == M_DOWN))) begin
      pend_valid <= 1'b1;
      pend_up    <= (M == M_UP);
    end
  end

  always_comb begin
    if (pend_valid) begin
      eval_up   = pend_up;
      eval_down = !pend_up;
    end else begin
      eval_up   = (M == M_UP);
      eval_down = (M == M_DOWN);
    end
  end
`else
  always_comb begin
    eval_up   = (M == M_UP);
    eval_down = (M == M_DOWN);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset || !AC) begin
      state      <= StOff;
      gear       <= GEAR_NEUTRAL;
      clutch     <= 1'b1;
      busy       <= 1'b0;
      shift_done <= 1'b0;
      reject     <= 1'b0;
      dir_up     <= 1'b0;
    end else begin
      shift_done <= 1'b0;
      reject     <= 1'b0;
      unique case (state)
        StOff: begin
          state  <= StIdle;
          gear   <= GEAR_FIRST;
          clutch <= 1'b0;
          busy   <= 1'b0;
        end
        StIdle: begin
          if (eval_up) begin
            if (gear < GEAR_TOP) begin
              dir_up <= 1'b1;
              state  <= StDisengage;
              clutch <= 1'b1;
              busy   <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end else if (eval_down) begin
            if (gear > GEAR_FIRST) begin
              dir_up <= 1'b0;
              state  <= StDisengage;
              clutch <= 1'b1;
              busy   <= 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        StDisengage: begin
          if (tmr_zero) begin
            state <= StSelect;
            gear  <= dir_up ? (gear + 3'd1) : (gear - 3'd1);
          end
        end
        StSelect: begin
          state      <= StEngage;
          clutch     <= 1'b0;
          shift_done <= 1'b1;
        end
        StEngage: begin
          state <= StSettle;
        end
        StSettle: begin
          if (tmr_zero) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StOff;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a default-parameter instance and a small one
// (CLUTCH_CYC=1, SETTLE_CYC=1, NUM_GEARS=2) share the same stimulus. Each is
// compared every cycle against a schedule-based model of the shift timeline.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       AC;
  logic [1:0] M;

  logic [2:0] gear_a, gear_b;
  logic       clutch_a, clutch_b, busy_a, busy_b;
  logic       done_a, done_b, rej_a, rej_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .NUM_GEARS  (5),
    .CLUTCH_CYC (4),
    .SETTLE_CYC (8)
  ) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .AC         (AC),
    .M          (M),
    .gear       (gear_a),
    .clutch     (clutch_a),
    .busy       (busy_a),
    .shift_done (done_a),
    .reject     (rej_a)
  );

  shift_sequencer #(
    .NUM_GEARS  (2),
    .CLUTCH_CYC (1),
    .SETTLE_CYC (1)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .AC         (AC),
    .M          (M),
    .gear       (gear_b),
    .clutch     (clutch_b),
    .busy       (busy_b),
    .shift_done (done_b),
    .reject     (rej_b)
  );

  // k counts cycles into an accepted shift (0 = not shifting). Cycle k of a
  // shift: clutch open for k<=C+1, new gear from k=C+1, done at k=C+2,
  // busy through k=C+2+S.
  typedef struct {
    bit on;
    int gear;
    int k;
    bit up;
    bit rej;
    bit done;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(input mdl_t s, input bit rst_n, input bit ac,
                                input logic [1:0] m, input int c, input int st,
                                input int ng);
    mdl_t n;
    n      = s;
    n.rej  = 1'b0;
    n.done = 1'b0;
    if (!rst_n || !ac) begin
      n.on   = 1'b0;
      n.gear = 0;
      n.k    = 0;
    end else if (!s.on) begin
      n.on   = 1'b1;
      n.gear = 1;
      n.k    = 0;
    end else if (s.k > 0) begin
      n.k = s.k + 1;
      if (n.k > c + 2 + st) begin
        n.k = 0;
      end else begin
        if (n.k == c + 1) n.gear = s.up ? s.gear + 1 : s.gear - 1;
        if (n.k == c + 2) n.done = 1'b1;
      end
    end else if (m == 2'b01) begin
      if (s.gear < ng) begin
        n.k  = 1;
        n.up = 1'b1;
      end else begin
        n.rej = 1'b1;
      end
    end else if (m == 2'b10) begin
      if (s.gear > 1) begin
        n.k  = 1;
        n.up = 1'b0;
      end else begin
        n.rej = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare(input string pfx, input mdl_t s, input int c,
                         input logic [2:0] g, input logic cl, input logic bz,
                         input logic dn, input logic rj);
    logic exp_clutch;
    exp_clutch = !s.on || ((s.k >= 1) && (s.k <= c + 1));
    check({pfx, ".gear"},       32'(g),  32'(s.gear));
    check({pfx, ".clutch"},     32'(cl), 32'(exp_clutch));
    check({pfx, ".busy"},       32'(bz), 32'(s.on && (s.k > 0)));
    check({pfx, ".shift_done"}, 32'(dn), 32'(s.done));
    check({pfx, ".reject"},     32'(rj), 32'(s.rej));
  endtask

  task automatic cyc(input bit r, input bit ac, input logic [1:0] m);
    reset = r;
    AC    = ac;
    M     = m;
    @(posedge clk);
    ma = step(ma, r, ac, m, 4, 8, 5);
    mb = step(mb, r, ac, m, 1, 1, 2);
    @(negedge clk);
    compare("a", ma, 4, gear_a, clutch_a, busy_a, done_a, rej_a);
    compare("b", mb, 1, gear_b, clutch_b, busy_b, done_b, rej_b);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    logic [1:0] m;
    bit         ac;
    int         r;
    ma    = '{default: 0};
    mb    = '{default: 0};
    reset = 1'b0;
    AC    = 1'b1;
    M     = 2'b00;

    // Reset with AC high, then power-up
    cyc(1'b0, 1'b1, 2'b00);
    cyc(1'b0, 1'b1, 2'b00);
    cyc(1'b1, 1'b1, 2'b00);
    // Down at gear 1 is refused
    cyc(1'b1, 1'b1, 2'b10);
    hold(2);
    // Single upshift and full timeline
    cyc(1'b1, 1'b1, 2'b01);
    hold(16);
    // Power loss during DISENGAGE, then power back
    cyc(1'b1, 1'b1, 2'b01);
    hold(2);
    cyc(1'b1, 1'b0, 2'b00);
    hold(3);
    // Climb to the top gear, then one more up is refused
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 2'b01);
      hold(15);
    end
    cyc(1'b1, 1'b1, 2'b01);
    hold(2);
    // Request while busy (in SETTLE) is dropped
    cyc(1'b1, 1'b1, 2'b10);
    hold(9);
    cyc(1'b1, 1'b1, 2'b10);
    hold(10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      m  = (r < 50) ? 2'b00 : (r < 75) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      ac = ($urandom_range(0, 59) != 0);
      cyc(($urandom_range(0, 499) != 0), ac, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Automatic shift sequencer for the gearbox. It consumes the 2-bit shift-type command `M` and the car-on flag `AC` from the gearbox FSM pair, and runs each accepted shift through a timed clutch-out / select / clutch-in sequence. It outputs the engaged gear, the clutch actuator and status pulses. It is the only block that changes the gear register.

## Interface
- `NUM_GEARS`, default 5: highest forward gear. Legal range 2..7.
- `CLUTCH_CYC`, default 4: cycles the clutch is held open before gear select. Must be ≥1.
- `SETTLE_CYC`, default 8: hold-off cycles after clutch-in before the next request is accepted. Must be ≥1.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `AC`  in  1: car on, from the gearbox Mealy FSM.
- `M`  in  2: shift command. 00 hold, 01 up, 10 down, 11 reserved (treated as hold).
- `gear`  out  3: engaged gear. 0 = neutral, 1..NUM_GEARS = forward gears.
- `clutch`  out  1: 1 = clutch disengaged (open).
- `busy`  out  1: 1 while a shift or settle is in progress.
- `shift_done`  out  1: one-cycle pulse when the clutch re-engages.
- `reject`  out  1: one-cycle pulse when an illegal request is refused.

## Operation
- States: OFF, IDLE, DISENGAGE, SELECT, ENGAGE, SETTLE. All outputs are registered.
- **OFF:** `gear`=0, `clutch`=1, `busy`=0.
  - `AC`=1 → IDLE; `gear` is loaded with 1 on the transition.
- **IDLE:** `clutch`=0, `busy`=0.
  - Up request with `gear`<NUM_GEARS, or down request with `gear`>1 → latch the direction, then DISENGAGE.
  - Up at top gear or down at gear 1 → `reject` pulse, stay in IDLE.
  - Hold or 11 → stay in IDLE.
- **DISENGAGE:** `clutch`=1, `busy`=1. Lasts CLUTCH_CYC cycles, then SELECT.
- **SELECT:** one cycle. `gear` is incremented or decremented per the latched direction. `clutch` stays 1.
- **ENGAGE:** one cycle. `clutch`=0, `shift_done`=1.
- **SETTLE:** `busy`=1, `clutch`=0. Lasts SETTLE_CYC cycles, then IDLE.
- **Requests while busy:** dropped, with no `reject` (see Configuration).
- **Power loss:** `AC`=0 in any state → OFF on the next edge. Takes priority over all other transitions; any shift in flight is abandoned, `gear`=0, `clutch`=1.
- **Arithmetic:**
  - Gear arithmetic never wraps; legality is checked before the update.
  - Counter width is `$clog2(max(CLUTCH_CYC,SETTLE_CYC)+1)`.

## Timing
- Reset (`reset`=0 at an edge): state OFF, `gear`=0, `clutch`=1, `busy`=0, `shift_done`=0, `reject`=0, pending cleared.
- Accepted request sampled in IDLE at cycle t:
  - t+1 … t+CLUTCH_CYC: DISENGAGE.
  - t+CLUTCH_CYC+1: SELECT; new `gear` is visible.
  - t+CLUTCH_CYC+2: ENGAGE; `shift_done`=1.
  - The following SETTLE_CYC cycles: SETTLE.
  - Total `busy` high = CLUTCH_CYC+2+SETTLE_CYC cycles (14 at defaults).
- Rejected request at t: `reject`=1 at t+1 only.
- `AC` falling at t: OFF outputs at t+1.
- `AC` rising at t (from OFF): IDLE with `gear`=1 at t+1. First request is accepted at t+1.

## Configuration
- `SHIFT_QUEUE_EN` defined: a one-deep pending register captures the most recent non-hold `M` seen while `busy`=1; a later request overwrites an earlier one.
  - On the cycle IDLE is entered, the pending request is evaluated as if sampled in IDLE (accept or `reject`), then cleared. A live `M` in that same cycle is ignored.
  - Pending is cleared by reset and by `AC`=0.
- `SHIFT_QUEUE_EN` undefined: no pending register; requests while busy are silently dropped.

## Structure
- Package `caja_pkg` holds:
  - the state enum `shift_state_t`;
  - the command constants `M_HOLD`=2'b00, `M_UP`=2'b01, `M_DOWN`=2'b10;
  - `GEAR_NEUTRAL`=3'd0.
- Sub-module `shift_timer`: loadable down-counter with load value, enable, and a `zero` flag. One instance is shared by DISENGAGE and SETTLE and reloaded on each state entry.

## Test plan
Defaults are used unless noted.
1. **Reset, then power-up:** reset low 2 cycles, `AC`=1 → `gear`=0 and `clutch`=1 during reset; `gear`=1 and `clutch`=0 one cycle after `AC` is sampled.
2. **Single upshift:** `M`=01 for 1 cycle from gear 1 → `clutch`=1 for 5 cycles, `gear`=2 at t+5, `shift_done` at t+6, `busy` high exactly 14 cycles.
3. **Boundary rejects:**
   - `M`=10 at gear 1 → `reject` pulse, `gear` stays 1, `busy` stays 0.
   - Drive to gear 5, then `M`=01 → `reject`, `gear` stays 5.
4. **Power loss mid-shift:** `AC`=0 during DISENGAGE → next cycle OFF, `gear`=0, `clutch`=1, no `shift_done`.
5. **Request while busy:** `M`=01 issued during SETTLE.
   - Without `SHIFT_QUEUE_EN`: dropped, `gear` unchanged.
   - With it: second shift starts on IDLE entry, `gear` goes 2→3.
6. **Parameter sweep:** `CLUTCH_CYC`=1, `SETTLE_CYC`=1, `NUM_GEARS`=2 → `busy` 4 cycles per shift, upshift at gear 2 rejected.
